// File: rtl/con_pkg.sv
// Shared definitions for the convolution output stage.
// Provides default data width and feature-map size, the FILL/DRAIN state
// encoding and a constant-evaluable clog2 helper for sizing address buses.
package con_pkg;

  localparam int unsigned DW_DEF    = 16;
  // 7x7 image convolved with a 3x3 kernel (no padding) gives a 5x5 map.
  localparam int unsigned OUT_H_DEF = 5;
  localparam int unsigned OUT_W_DEF = 5;

  typedef enum logic {
    StFill  = 1'b0,
    StDrain = 1'b1
  } state_e;

  // Minimum result of 1 so a one-entry buffer still gets a legal bus width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    while ((64'd1 << bits) < 64'(value)) begin
      bits = bits + 1;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/con_snake_addr.sv
// Write-position counter for the result buffer.
// Walks a OUT_H x OUT_W map either in raster order or, with SNAKE=1, in
// serpentine order (even rows left-to-right, odd rows right-to-left).
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, returns to (0,0)
//   step - advance to the next position this cycle
//   row  - current row
//   col  - current column
//   wrap - step taken at the final position; counters return to (0,0)
module con_snake_addr #(
  parameter int unsigned OUT_H = 5,
  parameter int unsigned OUT_W = 5,
  parameter bit          SNAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       wrap
);

  localparam logic [2:0] LastRow = 3'(OUT_H - 1);
  localparam logic [2:0] LastCol = 3'(OUT_W - 1);

  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic       desc;
  logic       row_end;

  assign desc    = SNAKE && row_q[0];
  assign row_end = desc ? (col_q == 3'd0) : (col_q == LastCol);
  assign wrap    = step && row_end && (row_q == LastRow);
  assign row     = row_q;
  assign col     = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (step) begin
      if (row_end) begin
        if (row_q == LastRow) begin
          row_d = 3'd0;
          col_d = 3'd0;
        end else begin
          row_d = row_q + 3'd1;
          // Leaving an even row means the next row is odd, which runs backwards.
          col_d = (SNAKE && !row_q[0]) ? LastCol : 3'd0;
        end
      end else if (desc) begin
        col_d = col_q - 3'd1;
      end else begin
        col_d = col_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= 3'd0;
      col_q <= 3'd0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/con_result_buf.sv
// Convolution result buffer.
// Captures one full feature map from the free-running convolution engine
// (raster or serpentine order), then replays it in raster order over a
// valid/ready handshake with optional ReLU clamping.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid, in_data        - result stream from the engine (no back-pressure)
//   out_ready                - consumer accepts the presented element
//   out_valid, out_data      - registered output element, raster order
//   out_row, out_col         - coordinates of out_data
//   out_last                 - marks element (OUT_H-1, OUT_W-1)
//   busy                     - high while draining
//   overflow                 - sticky: a sample arrived while not filling
module con_result_buf
  import con_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned OUT_H = OUT_H_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter bit          RELU  = 1'b0,
  parameter bit          SNAKE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [2:0]    out_row,
  output logic [2:0]    out_col,
  output logic          out_last,
  output logic          busy,
  output logic          overflow
);

  localparam int unsigned Depth   = OUT_H * OUT_W;
  localparam int unsigned AW      = clog2(Depth);
  localparam logic [2:0]  LastRow = 3'(OUT_H - 1);
  localparam logic [2:0]  LastCol = 3'(OUT_W - 1);

  state_e state_q, state_d;

  logic [DW-1:0] mem [Depth];

  logic          wr_en;
  logic          wr_wrap;
  logic [2:0]    wr_row, wr_col;
  logic [AW-1:0] wr_addr;

  logic [2:0]    rd_row_q, rd_col_q;
  logic          rd_done_q;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_word;
  logic          rd_is_last;

  logic          out_valid_q, out_last_q, overflow_q;
  logic [DW-1:0] out_data_q;
  logic [2:0]    out_row_q, out_col_q;

  logic          load, xfer, last_xfer;

  // Samples outside FILL are dropped so a completed frame is never overwritten.
  assign wr_en   = (state_q == StFill) && in_valid;
  assign wr_addr = AW'(wr_row * OUT_W + wr_col);

  con_snake_addr #(
    .OUT_H (OUT_H),
    .OUT_W (OUT_W),
    .SNAKE (SNAKE)
  ) u_wr_addr (
    .clk  (clk),
    .rst  (rst),
    .step (wr_en),
    .row  (wr_row),
    .col  (wr_col),
    .wrap (wr_wrap)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= in_data;
    end
  end

  assign rd_addr    = AW'(rd_row_q * OUT_W + rd_col_q);
  assign rd_word    = mem[rd_addr];
  assign rd_is_last = (rd_row_q == LastRow) && (rd_col_q == LastCol);

  // Refill the output register whenever it is empty or being emptied this cycle.
  assign xfer      = out_valid_q && out_ready;
  assign last_xfer = xfer && out_last_q;
  assign load      = (state_q == StDrain) && !rd_done_q && (!out_valid_q || out_ready);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (wr_wrap) state_d = StDrain;
      StDrain: if (last_xfer) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFill;
      rd_row_q    <= 3'd0;
      rd_col_q    <= 3'd0;
      rd_done_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= 3'd0;
      out_col_q   <= 3'd0;
      overflow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == StDrain) && in_valid) begin
        overflow_q <= 1'b1;
      end
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= (RELU && rd_word[DW-1]) ? '0 : rd_word;
        out_row_q   <= rd_row_q;
        out_col_q   <= rd_col_q;
        out_last_q  <= rd_is_last;
        if (rd_is_last) begin
          rd_done_q <= 1'b1;
          rd_row_q  <= 3'd0;
          rd_col_q  <= 3'd0;
        end else if (rd_col_q == LastCol) begin
          rd_row_q <= rd_row_q + 3'd1;
          rd_col_q <= 3'd0;
        end else begin
          rd_col_q <= rd_col_q + 3'd1;
        end
      end else if (xfer) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      if (last_xfer) begin
        rd_done_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == StDrain);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_con_result_buf.sv
// Bench for con_result_buf: three instances (raster, serpentine, serpentine+ReLU)
// share one stimulus stream and are each checked against a frame-level model.
module tb_con_result_buf;

  localparam int N = 25;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        out_ready = 1'b0;

  logic        ov    [3];
  logic [15:0] od    [3];
  logic [2:0]  orow  [3];
  logic [2:0]  ocol  [3];
  logic        olast [3];
  logic        obusy [3];
  logic        oovf  [3];

  int checks = 0;
  int errors = 0;

  logic [15:0] frame [N];
  logic [15:0] expv  [3][N];

  always #5 clk = ~clk;

  con_result_buf #(.SNAKE(1'b0), .RELU(1'b0)) dut_raster (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
    .out_valid(ov[0]), .out_data(od[0]), .out_row(orow[0]), .out_col(ocol[0]),
    .out_last(olast[0]), .busy(obusy[0]), .overflow(oovf[0])
  );

  con_result_buf #(.SNAKE(1'b1), .RELU(1'b0)) dut_snake (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
    .out_valid(ov[1]), .out_data(od[1]), .out_row(orow[1]), .out_col(ocol[1]),
    .out_last(olast[1]), .busy(obusy[1]), .overflow(oovf[1])
  );

  con_result_buf #(.SNAKE(1'b1), .RELU(1'b1)) dut_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
    .out_valid(ov[2]), .out_data(od[2]), .out_row(orow[2]), .out_col(ocol[2]),
    .out_last(olast[2]), .busy(obusy[2]), .overflow(oovf[2])
  );

  // Place the k-th arrival at its map coordinate, then read the map in raster order.
  function automatic void build_expected();
    for (int inst = 0; inst < 3; inst++) begin
      for (int k = 0; k < N; k++) begin
        int r, p, c;
        logic [15:0] v;
        r = k / 5;
        p = k % 5;
        c = (inst != 0 && (r % 2) == 1) ? 4 - p : p;
        v = frame[k];
        if (inst == 2 && $signed(v) < 0) v = 16'h0;
        expv[inst][r * 5 + c] = v;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic random_frame();
    for (int k = 0; k < N; k++) frame[k] = 16'($urandom);
  endtask

  task automatic check_idle(input string tag, input logic exp_ovf);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || obusy[i] !== 1'b0 || oovf[i] !== exp_ovf) begin
        errors++;
        $display("FAIL %s inst%0d: valid/busy/overflow got %b%b%b expected 00%b",
                 tag, i, ov[i], obusy[i], oovf[i], exp_ovf);
      end
    end
  endtask

  task automatic feed_frame(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data = frame[k];
      tick();
    end
    in_valid = 1'b0;
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
  // inj: 0 none, 1 stray sample early in drain, 2 stray sample with last transfer.
  task automatic drain_frame(input int ready_mode, input int inj, input string tag,
                             output int cycles, output int first_valid);
    int idx;
    int it;
    bit hold;
    logic [15:0] pd [3];
    idx = 0;
    it = 0;
    hold = 1'b0;
    first_valid = -1;
    while (idx < N && it < 300) begin
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((it % 3) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = (inj == 1 && it == 3) || (inj == 2 && ov[0] && olast[0] && out_ready);
      in_data = 16'h1234;
      if (ov[0] && first_valid < 0) first_valid = it;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ov[i] !== (it >= 1) || obusy[i] !== 1'b1) begin
          errors++;
          $display("FAIL %s valid/busy inst%0d cyc%0d: got %b%b expected %b1",
                   tag, i, it, ov[i], obusy[i], (it >= 1));
        end
        if (ov[i] === 1'b1) begin
          checks++;
          if (od[i] !== expv[i][idx] || orow[i] !== 3'(idx / 5) || ocol[i] !== 3'(idx % 5)
              || olast[i] !== (idx == N - 1)) begin
            errors++;
            $display("FAIL %s elem%0d inst%0d: got data %h r%0d c%0d last %b expected %h r%0d c%0d last %b",
                     tag, idx, i, od[i], orow[i], ocol[i], olast[i], expv[i][idx], idx / 5,
                     idx % 5, (idx == N - 1));
          end
        end
        if (hold) begin
          checks++;
          if (od[i] !== pd[i]) begin
            errors++;
            $display("FAIL %s hold inst%0d: got %h expected %h", tag, i, od[i], pd[i]);
          end
        end
        pd[i] = od[i];
      end
      hold = ov[0] && !out_ready;
      if (ov[0] && out_ready) idx++;
      tick();
      it++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (idx != N) begin
      errors++;
      $display("FAIL %s drain count: got %0d expected %0d", tag, idx, N);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || obusy[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s post-drain inst%0d: valid/busy got %b%b expected 00",
                 tag, i, ov[i], obusy[i]);
      end
    end
    cycles = it;
  endtask

  task automatic check_ovf(input string tag, input logic exp_ovf);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (oovf[i] !== exp_ovf) begin
        errors++;
        $display("FAIL %s overflow inst%0d: got %b expected %b", tag, i, oovf[i], exp_ovf);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || olast[i] !== 1'b0 || obusy[i] !== 1'b0 || oovf[i] !== 1'b0
          || od[i] !== 16'h0 || orow[i] !== 3'd0 || ocol[i] !== 3'd0) begin
        errors++;
        $display("FAIL reset inst%0d: v%b l%b b%b o%b d%h r%0d c%0d expected all zero",
                 i, ov[i], olast[i], obusy[i], oovf[i], od[i], orow[i], ocol[i]);
      end
    end
  endtask

  task automatic test_order_and_latency();
    int cycles, first;
    for (int k = 0; k < N; k++) frame[k] = 16'(k + 1);
    build_expected();
    feed_frame(N);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obusy[i] !== 1'b1 || ov[i] !== 1'b0) begin
        errors++;
        $display("FAIL after_last_write inst%0d: busy/valid got %b%b expected 10",
                 i, obusy[i], ov[i]);
      end
    end
    drain_frame(0, 0, "order", cycles, first);
    checks++;
    if (first != 1) begin
      errors++;
      $display("FAIL first_valid_latency: got %0d expected 1", first);
    end
    checks++;
    if (cycles != N + 1) begin
      errors++;
      $display("FAIL throughput: got %0d cycles expected %0d", cycles, N + 1);
    end
  endtask

  task automatic test_backpressure();
    int cycles, first;
    random_frame();
    build_expected();
    feed_frame(N);
    drain_frame(1, 0, "backpressure", cycles, first);
  endtask

  task automatic test_relu();
    int cycles, first;
    for (int k = 0; k < N; k++) frame[k] = (k % 2 == 0) ? 16'd100 : 16'hFF9C;
    build_expected();
    feed_frame(N);
    drain_frame(0, 0, "relu", cycles, first);
  endtask

  task automatic test_overflow();
    int cycles, first;
    random_frame();
    build_expected();
    feed_frame(N);
    drain_frame(2, 1, "ovf_drain", cycles, first);
    check_ovf("ovf_set", 1'b1);
    random_frame();
    build_expected();
    feed_frame(N);
    drain_frame(0, 0, "ovf_next_frame", cycles, first);
    check_ovf("ovf_sticky", 1'b1);
    do_reset();
    check_ovf("ovf_cleared", 1'b0);
    random_frame();
    build_expected();
    feed_frame(N);
    drain_frame(0, 2, "ovf_last_xfer", cycles, first);
    check_ovf("ovf_on_last", 1'b1);
    random_frame();
    build_expected();
    feed_frame(N);
    drain_frame(2, 0, "after_last_drop", cycles, first);
  endtask

  task automatic test_midframe_reset();
    int cycles, first;
    random_frame();
    feed_frame(12);
    do_reset();
    check_idle("midframe_reset", 1'b0);
    random_frame();
    build_expected();
    feed_frame(N);
    drain_frame(0, 0, "fresh_frame", cycles, first);
  endtask

  task automatic test_random_frames();
    int cycles, first;
    for (int f = 0; f < 4; f++) begin
      random_frame();
      build_expected();
      feed_frame(N);
      drain_frame(2, 0, "random", cycles, first);
    end
  endtask

  initial begin
    test_reset();
    test_order_and_latency();
    test_backpressure();
    test_relu();
    test_overflow();
    test_midframe_reset();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/con_result_buf.md
Name: con_result_buf

Overview:
Output stage directly downstream of the 3x3 convolution engine. It captures the engine's serpentine-ordered stream of 16-bit convolution results (one full 5x5 feature map per frame) into an internal buffer. It then replays the map in raster order over a valid/ready handshake, optionally clamping negatives to zero (ReLU). It decouples the free-running engine from a back-pressuring consumer (memory writer or next layer).

Parameters:
DW, 16, result/data width (signed two's complement)
OUT_H, 5, feature-map rows
OUT_W, 5, feature-map columns
RELU, 0, 1 = replace negative results with 0 on output
SNAKE, 1, 1 = input order is serpentine by row; 0 = raster

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous, active-high reset
in_valid  in  1  one result present on in_data this cycle (no back-pressure to engine)
in_data  in  DW  signed convolution result
out_ready  in  1  consumer accepts out_data this cycle
out_valid  out  1  out_data/out_row/out_col hold a valid element
out_data  out  DW  feature-map element, raster order
out_row  out  3  row index of out_data (0..OUT_H-1)
out_col  out  3  column index of out_data (0..OUT_W-1)
out_last  out  1  high with the final element (row OUT_H-1, col OUT_W-1)
busy  out  1  high while in DRAIN state
overflow  out  1  sticky: an in_valid sample arrived while not in FILL

Behaviour:
- Reset (rst=1 at clk edge): state=FILL, write row/col counters=0, read counters=0, out_valid=0, out_last=0, out_row=0, out_col=0, out_data=0, busy=0, overflow=0. Buffer contents are not cleared. Reset mid-frame discards the partial frame.
- Buffer: OUT_H*OUT_W words of DW bits. Address = row*OUT_W + col. Address width = clog2(OUT_H*OUT_W).
- FILL state: each in_valid cycle writes in_data at the current (wr_row, wr_col), then advances the write position.
  - Row r even, or SNAKE=0: wr_col increments. Row r odd with SNAKE=1: wr_col decrements.
  - At the row end (col OUT_W-1 ascending, or col 0 descending): wr_row+1, and wr_col = 0 for the next even row or OUT_W-1 for the next odd row (SNAKE=1); always 0 when SNAKE=0.
  - Write of element OUT_H*OUT_W: next cycle state=DRAIN, busy=1, write counters reset to 0.
- DRAIN state: reads raster order (row 0 col 0 .. row OUT_H-1 col OUT_W-1).
  - First out_valid rises on the 2nd clk after the final write (1 cycle state change + 1 cycle registered read).
  - Transfer occurs when out_valid & out_ready. While out_valid & !out_ready, out_data/row/col/last hold stable. A next element may be presented in the cycle immediately after a transfer, allowing full throughput of 1 element/cycle with out_ready held high.
  - RELU=1: out_data = 0 if stored MSB=1, else stored value. Applied on the output register.
  - out_last=1 only with element (OUT_H-1, OUT_W-1). On its transfer: out_valid=0, busy=0, state=FILL next cycle.
- in_valid while in DRAIN: sample dropped, overflow set, and held until rst. The buffer is never corrupted.
- in_valid in the same cycle as the last-element transfer: still DRAIN, so the sample is dropped and overflow is set.
- out_ready is ignored when out_valid=0.

Decomposition:
- Shared package con_pkg: DW default, OUT_H/OUT_W defaults (5/5 for a 7x7 image with a 3x3 kernel), state encoding FILL=1'b0/DRAIN=1'b1, clog2 helper function.
- One natural sub-module, con_snake_addr: write row/col counter with serpentine direction logic. Ports: clk, rst, step, row, col, wrap.

Test Plan:
- Raster identity, SNAKE=0: write values 1..25 with in_valid every cycle and out_ready=1 -> out_data 1..25 in order; first out_valid 2 cycles after the 25th write; out_last on 25 with row=4, col=4; busy falls the cycle after.
- Serpentine reorder, SNAKE=1: feed 1..25 -> raster output row0=1,2,3,4,5; row1=10,9,8,7,6; row2=11..15; row3=20..16; row4=21..25.
- Back-pressure: toggle out_ready 1,0,0,1,... during drain -> no element lost or duplicated; out_data stable in every out_ready=0 cycle; 25 transfers total.
- ReLU: RELU=1, inputs alternate 16'sd100 and -16'sd100 (16'hFF9C) -> outputs alternate 100 and 0; RELU=0 passes 16'hFF9C unchanged.
- Overflow: send in_valid with 16'h1234 during drain -> overflow=1 and stays 1; drained data unaffected; the next frame fills normally.
- Mid-frame reset: rst after 12 writes, then a fresh 25-value frame -> output equals the fresh frame only; out_valid=0 and overflow=0 immediately after reset.
